// File: rtl/cby_param_shadow_pkg.sv
// Shared types and elaboration-time helpers for the Y-direction connection block.
// Optional readback of the committed configuration is enabled with CBY_READBACK_EN.
package cby_pkg;

    typedef enum logic [1:0] {
        CFG_IDLE = 2'd0,
        CFG_LOAD = 2'd1,
        CFG_FULL = 2'd2
    } cfg_state_e;

    // Track feeding tap j of the mux for pin k; taps walk the channel with a fixed stride.
    function automatic int cby_tap_idx(input int k, input int j, input int stride, input int chan_w);
        return (k + j * stride) % chan_w;
    endfunction

    function automatic int cby_sram_w(input int mux_size);
        return $clog2(mux_size);
    endfunction

    function automatic int cby_chain_len(input int num_ipin, input int mux_size);
        return num_ipin * cby_sram_w(mux_size);
    endfunction

endpackage

// File: rtl/cby_param_shadow_if.sv
// Channel, pin and configuration-chain signals of the connection block.
// ccff_readback exists only when CBY_READBACK_EN is defined.
interface cby_param_shadow_if #(
    parameter int CHAN_W   = 30,
    parameter int NUM_IPIN = 4
);
    logic [CHAN_W-1:0]   chany_bottom_in;
    logic [CHAN_W-1:0]   chany_top_in;
    logic [CHAN_W-1:0]   chany_bottom_out;
    logic [CHAN_W-1:0]   chany_top_out;
    logic                ccff_head;
    logic                ccff_shift_en;
    logic                ccff_commit;
`ifdef CBY_READBACK_EN
    logic                ccff_readback;
`endif
    logic [NUM_IPIN-1:0] ipin_out;
    logic                ccff_tail;
    logic                cfg_valid;
    logic                cfg_err;

    modport slave (
        input  chany_bottom_in,
        input  chany_top_in,
        input  ccff_head,
        input  ccff_shift_en,
        input  ccff_commit,
`ifdef CBY_READBACK_EN
        input  ccff_readback,
`endif
        output chany_bottom_out,
        output chany_top_out,
        output ipin_out,
        output ccff_tail,
        output cfg_valid,
        output cfg_err
    );

    modport master (
        output chany_bottom_in,
        output chany_top_in,
        output ccff_head,
        output ccff_shift_en,
        output ccff_commit,
`ifdef CBY_READBACK_EN
        output ccff_readback,
`endif
        input  chany_bottom_out,
        input  chany_top_out,
        input  ipin_out,
        input  ccff_tail,
        input  cfg_valid,
        input  cfg_err
    );

endinterface

// File: rtl/cby_param_shadow_cfg_chain.sv
// Double-buffered configuration chain: serial shift register, fill counter, shadow copy
// and protocol error tracking. Readback (CBY_READBACK_EN) reloads the chain from the shadow.
module cby_cfg_chain
    import cby_pkg::*;
#(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset,
    input  logic                 head,
    input  logic                 shift_en,
`ifdef CBY_READBACK_EN
    input  logic                 readback,
`endif
    input  logic                 commit,
    output logic [CHAIN_LEN-1:0] shadow,
    output logic                 tail,
    output logic                 cfg_valid,
    output logic                 cfg_err
);

    localparam int                CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CHAIN_LEN);

    logic [CHAIN_LEN-1:0] chain_q, chain_d;
    logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    cfg_state_e state_s;
    logic       readback_s;
    logic       draining_s;
    logic       commit_ok_s;
    logic       readback_ok_s;
    logic       overshift_s;
    logic       bad_cmd_s;

`ifdef CBY_READBACK_EN
    assign readback_s = readback;
`else
    assign readback_s = 1'b0;
`endif

    // Decode the fill level into the configuration state.
    always_comb begin
        state_s = CFG_LOAD;
        if (cnt_q == CNT_ZERO) begin
            state_s = CFG_IDLE;
        end else if (cnt_q == CNT_FULL) begin
            state_s = CFG_FULL;
        end else begin
            state_s = CFG_LOAD;
        end
    end

    // Command legality: a command is honoured only alone and in the right state.
    always_comb begin
        commit_ok_s   = commit && !shift_en && !readback_s && (state_s == CFG_FULL);
        readback_ok_s = readback_s && !shift_en && !commit && (state_s != CFG_LOAD);
        overshift_s   = shift_en && (state_s == CFG_FULL) && !draining_s;
        bad_cmd_s     = (commit && !commit_ok_s) || (readback_s && !readback_ok_s);
    end

    // Next-state for chain, counter, shadow and status flags.
    always_comb begin
        chain_d  = chain_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        valid_d  = valid_q;
        err_d    = err_q | overshift_s | bad_cmd_s;
        case (1'b1)
            shift_en: begin
                chain_d = {chain_q[CHAIN_LEN-2:0], head};
                if (state_s == CFG_FULL) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            commit_ok_s: begin
                shadow_d = chain_q;
                cnt_d    = CNT_ZERO;
                valid_d  = 1'b1;
            end
            readback_ok_s: begin
                chain_d = shadow_q;
                cnt_d   = CNT_FULL;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Configuration state registers.
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            chain_q  <= {CHAIN_LEN{1'b0}};
            shadow_q <= {CHAIN_LEN{1'b0}};
            cnt_q    <= CNT_ZERO;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            chain_q  <= chain_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

`ifdef CBY_READBACK_EN
    logic [CNT_W-1:0] drain_q, drain_d;

    // Bits of a readback image still to drain; shifting these out is not an overshift.
    always_comb begin
        drain_d = drain_q;
        if (readback_ok_s) begin
            drain_d = CNT_FULL;
        end else if (commit_ok_s) begin
            drain_d = CNT_ZERO;
        end else if (shift_en && (drain_q != CNT_ZERO)) begin
            drain_d = drain_q - CNT_W'(1);
        end else begin
            drain_d = drain_q;
        end
    end

    // Readback drain counter register.
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            drain_q <= CNT_ZERO;
        end else begin
            drain_q <= drain_d;
        end
    end

    assign draining_s = (drain_q != CNT_ZERO);
`else
    assign draining_s = 1'b0;
`endif

    assign shadow    = shadow_q;
    assign tail      = chain_q[CHAIN_LEN-1];
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

endmodule

// File: rtl/cby_param_shadow.sv
// Y-direction connection block: channel pass-through plus NUM_IPIN shadow-configured pin muxes.
// Define CBY_READBACK_EN to add ccff_readback (reload chain from the committed shadow).
module cby_param_shadow
    import cby_pkg::*;
#(
    parameter int CHAN_W   = 30,
    parameter int NUM_IPIN = 4,
    parameter int MUX_SIZE = 12,   // even, at most 2*CHAN_W
    parameter int STRIDE   = 3
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset,
    cby_param_shadow_if.slave    bus
);

    localparam int SRAM_W    = cby_sram_w(MUX_SIZE);
    localparam int CHAIN_LEN = cby_chain_len(NUM_IPIN, MUX_SIZE);
    localparam logic [SRAM_W:0] SEL_LIMIT = (SRAM_W + 1)'(MUX_SIZE);

    logic [CHAIN_LEN-1:0] shadow_s;
    logic [NUM_IPIN-1:0]  ipin_s;
    logic                 tail_s;
    logic                 valid_s;
    logic                 err_s;

    assign bus.chany_bottom_out = bus.chany_top_in;
    assign bus.chany_top_out    = bus.chany_bottom_in;

    cby_cfg_chain #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_cfg_chain (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .head       (bus.ccff_head),
        .shift_en   (bus.ccff_shift_en),
`ifdef CBY_READBACK_EN
        .readback   (bus.ccff_readback),
`endif
        .commit     (bus.ccff_commit),
        .shadow     (shadow_s),
        .tail       (tail_s),
        .cfg_valid  (valid_s),
        .cfg_err    (err_s)
    );

    for (genvar k = 0; k < NUM_IPIN; k++) begin : g_pin
        logic [MUX_SIZE-1:0] tap_s;
        logic [SRAM_W-1:0]   sel_s;
        logic                in_range_s;
        logic                pin_s;

        // Pin 0 owns the most-significant word because it is shifted in first.
        assign sel_s      = shadow_s[CHAIN_LEN-1-k*SRAM_W -: SRAM_W];
        assign in_range_s = ({1'b0, sel_s} < SEL_LIMIT);

        for (genvar j = 0; j < MUX_SIZE / 2; j++) begin : g_tap
            localparam int TRK = cby_tap_idx(k, j, STRIDE, CHAN_W);
            assign tap_s[2*j]   = bus.chany_bottom_in[TRK];
            assign tap_s[2*j+1] = bus.chany_top_in[TRK];
        end

        // Routing mux; unconfigured or out-of-range selects drive the pin low.
        always_comb begin
            pin_s = 1'b0;
            if (valid_s && in_range_s) begin
                pin_s = tap_s[sel_s];
            end else begin
                pin_s = 1'b0;
            end
        end

        assign ipin_s[k] = pin_s;
    end

    assign bus.ipin_out  = ipin_s;
    assign bus.ccff_tail = tail_s;
    assign bus.cfg_valid = valid_s;
    assign bus.cfg_err   = err_s;

endmodule

// File: tb/tb_cby_param_shadow.sv
// Directed, table-driven bench for cby_param_shadow with default parameters.
module tb_cby_param_shadow;

    typedef struct {
        logic [29:0] bot;
        logic [29:0] top;
        logic [3:0]  exp_a;   // sel = {0,1,5,11}
        logic [3:0]  exp_b;   // sel = {0,1,13,11}
    } vec_t;

    localparam logic [15:0] CFG_A  = 16'h015B;
    localparam logic [15:0] CFG_B  = 16'h01DB;
    localparam logic [29:0] ALL1   = 30'h3FFF_FFFF;

    logic clk = 1'b0;
    logic prog_reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[9];

    cby_param_shadow_if #(.CHAN_W(30), .NUM_IPIN(4)) bus ();

    cby_param_shadow dut (
        .prog_clk   (clk),
        .prog_reset (prog_reset),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic shift_bit(input logic b);
        bus.ccff_head     = b;
        bus.ccff_shift_en = 1'b1;
        @(negedge clk);
        bus.ccff_shift_en = 1'b0;
        bus.ccff_head     = 1'b0;
    endtask

    task automatic shift_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic pulse_commit();
        bus.ccff_commit = 1'b1;
        @(negedge clk);
        bus.ccff_commit = 1'b0;
    endtask

    task automatic do_reset();
        prog_reset = 1'b0;
        @(negedge clk);
        prog_reset = 1'b1;
    endtask

    task automatic set_tracks(input logic [29:0] b, input logic [29:0] t);
        bus.chany_bottom_in = b;
        bus.chany_top_in    = t;
    endtask

    task automatic run_table(input bit use_b);
        for (int i = 0; i < 9; i++) begin
            set_tracks(vecs[i].bot, vecs[i].top);
            #1;
            check(use_b ? "ipin_cfg_b" : "ipin_cfg_a", bus.ipin_out, use_b ? vecs[i].exp_b : vecs[i].exp_a);
            check("bottom_out", bus.chany_bottom_out, vecs[i].top);
            check("top_out", bus.chany_top_out, vecs[i].bot);
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{30'h0000_0000, 30'h0000_0000, 4'b0000, 4'b0000};
        vecs[1] = '{30'h0000_0001, 30'h0000_0000, 4'b0001, 4'b0001};
        vecs[2] = '{30'h0000_0000, 30'h0000_0002, 4'b0010, 4'b0010};
        vecs[3] = '{30'h0000_0000, 30'h0000_0100, 4'b0100, 4'b0000};
        vecs[4] = '{30'h0000_0000, 30'h0004_0000, 4'b1000, 4'b1000};
        vecs[5] = '{ALL1,          ALL1,          4'b1111, 4'b1011};
        vecs[6] = '{30'h3FFF_FFFE, 30'h3FFB_FEFD, 4'b0000, 4'b0000};
        vecs[7] = '{ALL1,          30'h0000_0000, 4'b0001, 4'b0001};
        vecs[8] = '{30'h0000_0000, ALL1,          4'b1110, 4'b1010};

        bus.ccff_head     = 1'b0;
        bus.ccff_shift_en = 1'b0;
        bus.ccff_commit   = 1'b0;
`ifdef CBY_READBACK_EN
        bus.ccff_readback = 1'b0;
`endif
        set_tracks(ALL1, ALL1);

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_ipin", bus.ipin_out, 4'b0000);
        check("rst_tail", bus.ccff_tail, 1'b0);
        check("rst_valid", bus.cfg_valid, 1'b0);
        check("rst_err", bus.cfg_err, 1'b0);
        prog_reset = 1'b1;
        @(negedge clk);

        // Load and commit configuration A.
        shift_word(CFG_A);
        check("pre_commit_valid", bus.cfg_valid, 1'b0);
        check("pre_commit_ipin", bus.ipin_out, 4'b0000);
        pulse_commit();
        check("commit_valid", bus.cfg_valid, 1'b1);
        check("commit_err", bus.cfg_err, 1'b0);
        run_table(1'b0);

        // Reset in the middle of a reload.
        set_tracks(ALL1, ALL1);
        #1;
        check("old_cfg_ipin", bus.ipin_out, 4'b1111);
        @(negedge clk);
        for (int i = 0; i < 7; i++) shift_bit(1'b1);
        check("midload_ipin", bus.ipin_out, 4'b1111);
        check("midload_valid", bus.cfg_valid, 1'b1);
        check("midload_tail", bus.ccff_tail, CFG_A[8]);
        #2;
        prog_reset = 1'b0;
        #1;
        check("async_rst_ipin", bus.ipin_out, 4'b0000);
        check("async_rst_tail", bus.ccff_tail, 1'b0);
        check("async_rst_valid", bus.cfg_valid, 1'b0);
        check("async_rst_err", bus.cfg_err, 1'b0);
        @(negedge clk);
        prog_reset = 1'b1;

        // Fresh 16-bit load after reset; pin 2 select is out of range.
        shift_word(CFG_B);
        pulse_commit();
        check("cfg_b_err", bus.cfg_err, 1'b0);
        check("cfg_b_valid", bus.cfg_valid, 1'b1);
        run_table(1'b1);

        // Early commit after 15 shifts is ignored.
        set_tracks(30'h0000_0000, ALL1);
        for (int i = 15; i >= 1; i--) shift_bit(CFG_A[i]);
        pulse_commit();
        check("early_err", bus.cfg_err, 1'b1);
        check("early_valid", bus.cfg_valid, 1'b1);
        check("early_ipin", bus.ipin_out, 4'b1010);

        // Overshift.
        do_reset();
        shift_word(16'h8001);
        check("full_tail", bus.ccff_tail, 1'b1);
        check("full_err", bus.cfg_err, 1'b0);
        shift_bit(1'b0);
        check("overshift_err", bus.cfg_err, 1'b1);
        check("overshift_tail", bus.ccff_tail, 1'b0);

        // Commit together with a shift is ignored.
        do_reset();
        shift_word(CFG_A);
        bus.ccff_commit   = 1'b1;
        bus.ccff_shift_en = 1'b1;
        @(negedge clk);
        bus.ccff_commit   = 1'b0;
        bus.ccff_shift_en = 1'b0;
        check("commit_shift_err", bus.cfg_err, 1'b1);
        check("commit_shift_valid", bus.cfg_valid, 1'b0);

`ifdef CBY_READBACK_EN
        // Readback of the committed config through ccff_tail.
        do_reset();
        shift_word(CFG_A);
        pulse_commit();
        bus.ccff_readback = 1'b1;
        @(negedge clk);
        bus.ccff_readback = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            check("rb_tail", bus.ccff_tail, CFG_A[i]);
            shift_bit(1'b0);
        end
        check("rb_err", bus.cfg_err, 1'b0);
        check("rb_valid", bus.cfg_valid, 1'b1);
        shift_bit(1'b0);
        check("rb_overshift_err", bus.cfg_err, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
